// File: rtl/mini_alu_pipe_pkg.sv
// Shared definitions for the mini_alu_pipe core: instruction layout, opcodes,
// and the NOP word used for reset and for branch bubbles.
package mini_alu_pipe_pkg;

  localparam int unsigned INSTR_W = 28;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned FIELD_W = 8;

  // Field positions: [27:24] opcode, [23:16] dst, [15:8] src1, [7:0] src0
  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [FIELD_W-1:0] dst;
    logic [FIELD_W-1:0] src1;
    logic [FIELD_W-1:0] src0;
  } instr_t;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_STO  = 4'h3;
  localparam logic [OPC_W-1:0] OP_BLE  = 4'h4;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h5;
  localparam logic [OPC_W-1:0] OP_LED  = 4'h6;
  localparam logic [OPC_W-1:0] OP_OUT  = 4'h7;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h8;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h9;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'hA;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'hB;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'hC;
  localparam logic [OPC_W-1:0] OP_BNE  = 4'hD;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  localparam instr_t NOP_INSTR = '{opcode: OP_NOP, dst: 8'h00, src1: 8'h00, src0: 8'h00};

endpackage

// File: rtl/mini_alu_regfile.sv
// REGS x DATA_W register file: two combinational read ports, one synchronous
// write port, asynchronous clear.
module mini_alu_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REGS   = 8,
  localparam int unsigned AW    = $clog2(REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/mini_alu_pipe.sv
// Two-stage (FETCH/EXEC) mini ALU core fed by an external combinational ROM,
// with an LED register and a ready/valid byte output channel.
module mini_alu_pipe
  import mini_alu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REGS   = 8,
  parameter int unsigned IP_W   = 8,
  parameter int unsigned LED_W  = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [IP_W-1:0]    oIP,
  input  logic [INSTR_W-1:0] iInstruction,
  output logic [LED_W-1:0]   oLed,
  output logic [7:0]         oOutData,
  output logic               oOutValid,
  input  logic               iOutReady,
  output logic               oHalted
);

  localparam int unsigned AW   = $clog2(REGS);
  localparam int unsigned SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [IP_W-1:0]   ip;
  instr_t            ir;
  logic [LED_W-1:0]  led;
  logic              halted;

  logic [DATA_W-1:0] rs0, rs1, imm, wr_data;
  logic [SH_W-1:0]   shamt;
  logic              wr_en, take, led_en, halt_c, out_c, stall_c;

  mini_alu_regfile #(.DATA_W(DATA_W), .REGS(REGS)) u_regfile (
    .clk    (Clock),
    .rst_n  (Reset),
    .we     (wr_en),
    .waddr  (ir.dst[AW-1:0]),
    .wdata  (wr_data),
    .raddr0 (ir.src0[AW-1:0]),
    .raddr1 (ir.src1[AW-1:0]),
    .rdata0 (rs0),
    .rdata1 (rs1)
  );

  assign imm     = DATA_W'({ir.src1, ir.src0});
  assign shamt   = rs0[SH_W-1:0];
  assign out_c   = (ir.opcode == OP_OUT);
  assign stall_c = out_c & ~iOutReady;

  // EXEC decode: register write, branch decision, LED and HALT strobes
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    take    = 1'b0;
    led_en  = 1'b0;
    halt_c  = 1'b0;
    case (ir.opcode)
      OP_ADD:  begin wr_en = 1'b1; wr_data = rs1 + rs0;        end
      OP_SUB:  begin wr_en = 1'b1; wr_data = rs1 - rs0;        end
      OP_STO:  begin wr_en = 1'b1; wr_data = imm;              end
      OP_AND:  begin wr_en = 1'b1; wr_data = rs1 & rs0;        end
      OP_OR:   begin wr_en = 1'b1; wr_data = rs1 | rs0;        end
      OP_XOR:  begin wr_en = 1'b1; wr_data = rs1 ^ rs0;        end
      OP_SHL:  begin wr_en = 1'b1; wr_data = rs1 << shamt;     end
      OP_SHR:  begin wr_en = 1'b1; wr_data = rs1 >> shamt;     end
      OP_BLE:  take   = (rs1 <= rs0);
      OP_BNE:  take   = (rs1 != rs0);
      OP_JMP:  take   = 1'b1;
      OP_LED:  led_en = 1'b1;
      OP_HALT: halt_c = 1'b1;
      default: ;
    endcase
  end

  // FETCH: a taken branch injects one NOP bubble; OUT without ready holds IP/IR
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ip     <= '0;
      ir     <= NOP_INSTR;
      led    <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (halt_c) begin
        halted <= 1'b1;
      end else if (take) begin
        ip <= IP_W'(ir.dst);
        ir <= NOP_INSTR;
      end else if (!stall_c) begin
        ip <= ip + IP_W'(1);
        ir <= instr_t'(iInstruction);
      end
      if (led_en) led <= rs1[LED_W-1:0];
    end
  end

  assign oIP       = ip;
  assign oLed      = led;
  assign oHalted   = halted;
  assign oOutValid = out_c;
  assign oOutData  = rs1[7:0];

endmodule
